// File: rtl/bank_fifo_pkg.sv
// Shared constants for the bank-line FIFO: geometry, wait saturation and 7-segment codes.
// SEG_ACTIVE_LOW_EN selects the common-anode segment reset pattern.
package bank_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int THRESH = 8;

  localparam logic [7:0] WAIT_MAX = 8'd99;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_RST = 7'h40;
`else
  localparam logic [6:0] SEG_RST = 7'h3F;
`endif

  // Index of the highest set bit of a one-hot-ish 10-bit field; 0 when no bit is set.
  function automatic logic [3:0] msb_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bank_fifo_mem_seg7_decoder.sv
// Single 7-segment digit decoder, segments {g,f,e,d,c,b,a}.
// SEG_ACTIVE_LOW_EN inverts the segments for common-anode displays.
module seg7_decoder
  import bank_fifo_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  logic [6:0] raw_s;

  // Table lookup; digits above 9 blank the display.
  always_comb begin
    raw_s = 7'h00;
    if (digit_i < 4'd10) begin
      raw_s = SEG_TABLE[digit_i];
    end else begin
      raw_s = 7'h00;
    end
`ifdef SEG_ACTIVE_LOW_EN
    seg_o = ~raw_s;
`else
    seg_o = raw_s;
`endif
  end

endmodule

// File: rtl/bank_fifo_mem.sv
// 16x8 first-word-fall-through customer-line FIFO with wait-time estimate on two 7-seg digits.
// SEG_ACTIVE_LOW_EN (see seg7_decoder) selects common-anode segment polarity.
module bank_fifo_mem
  import bank_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  input  logic [9:0]        input1,
  input  logic [9:0]        input2,
  output logic [6:0]        seg1,
  output logic [6:0]        seg2,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_threshold,
  output logic              fifo_overflow,
  output logic              fifo_underflow,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_s;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc_s, rd_acc_s;
  logic [3:0]        t_s, n_s;
  logic [7:0]        prod_s, wait_s;
  logic [6:0]        seg1_q, seg2_q, seg_tens_s, seg_units_s;

  assign count_s        = wptr_q - rptr_q;
  assign fifo_empty     = (wptr_q == rptr_q);
  assign fifo_full      = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) && (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
  assign fifo_threshold = (count_s >= 5'(THRESH));
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = udf_q;
  assign data_out       = mem_q[rptr_q[ADDR_W-1:0]];
  assign seg1           = seg1_q;
  assign seg2           = seg2_q;

  // A read frees the slot a same-cycle write needs, so full+rd still accepts the write.
  always_comb begin
    wr_acc_s = wr & (~fifo_full | rd);
    rd_acc_s = rd & ~fifo_empty;
    ovf_d    = ovf_q | (wr & fifo_full & ~rd);
    udf_d    = udf_q | (rd & fifo_empty);
    if (wr_acc_s) begin
      wptr_d = wptr_q + 5'd1;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_acc_s) begin
      rptr_d = rptr_q + 5'd1;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer, sticky flag and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= 5'd0;
      rptr_q <= 5'd0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      seg1_q <= SEG_RST;
      seg2_q <= SEG_RST;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      seg1_q <= seg_tens_s;
      seg2_q <= seg_units_s;
    end
  end

  // Storage is deliberately not reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  // Ceiling division of count*T by N; count*T never exceeds 144 so 8 bits suffice.
  always_comb begin
    t_s    = msb_index(input1);
    n_s    = (msb_index(input2) == 4'd0) ? 4'd1 : msb_index(input2);
    prod_s = {3'b000, count_s} * {4'b0000, t_s};
    wait_s = (prod_s + {4'b0000, n_s} - 8'd1) / {4'b0000, n_s};
    if (wait_s > WAIT_MAX) begin
      wait_s = WAIT_MAX;
    end else begin
      wait_s = wait_s;
    end
  end

  seg7_decoder u_seg_tens (
    .digit_i (4'(wait_s / 8'd10)),
    .seg_o   (seg_tens_s)
  );

  seg7_decoder u_seg_units (
    .digit_i (4'(wait_s % 8'd10)),
    .seg_o   (seg_units_s)
  );

endmodule

// File: tb/tb_bank_fifo_mem.sv
// Self-checking bench for bank_fifo_mem: directed plan then random traffic against a queue model.
module tb_bank_fifo_mem;

  logic       clk = 1'b0;
  logic       rst_n, wr, rd;
  logic [7:0] data_in, data_out;
  logic [9:0] input1, input2;
  logic [6:0] seg1, seg2;
  logic       fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q [$];
  logic       m_ovf, m_udf;
  logic [6:0] m_seg1, m_seg2;

  localparam logic [6:0] DIGITS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  bank_fifo_mem dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
    .input1(input1), .input2(input2), .seg1(seg1), .seg2(seg2),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] panel(input int d);
    logic [6:0] s;
    s = DIGITS[d];
`ifdef SEG_ACTIVE_LOW_EN
    s = ~s;
`endif
    return s;
  endfunction

  function automatic int wait_min(input int cnt, input logic [9:0] a, input logic [9:0] b);
    int t, n, w;
    t = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (a[i]) t = i;
      if (b[i]) n = i;
    end
    if (n == 0) n = 1;
    w = (cnt * t + n - 1) / n;
    if (w > 99) w = 99;
    return w;
  endfunction

  task automatic compare_all();
    int c;
    c = q.size();
    check_eq("empty", fifo_empty, c == 0);
    check_eq("full", fifo_full, c == 16);
    check_eq("threshold", fifo_threshold, c >= 8);
    check_eq("overflow", fifo_overflow, m_ovf);
    check_eq("underflow", fifo_underflow, m_udf);
    check_eq("seg1", seg1, m_seg1);
    check_eq("seg2", seg2, m_seg2);
    if (c != 0) check_eq("data_out", data_out, q[0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_seg1 = panel(0);
    m_seg2 = panel(0);
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    int c, wt;
    compare_all();
    wr = w;
    rd = r;
    data_in = d;
    c = q.size();
    wt = wait_min(c, input1, input2);
    if (w && c == 16 && !r) m_ovf = 1'b1;
    if (r && c == 0) m_udf = 1'b1;
    if (r && c != 0) void'(q.pop_front());
    if (w && (c != 16 || r)) q.push_back(d);
    @(posedge clk);
    #1;
    m_seg1 = panel(wt / 10);
    m_seg2 = panel(wt % 10);
  endtask

  initial begin
    int k;
    logic [9:0] oh;
    rd = 1'b0; wr = 1'b0; data_in = 8'h00;
    input1 = 10'd0; input2 = 10'd0;
    do_reset();
    check_eq("rst_seg1", seg1, panel(0));
    check_eq("rst_empty", fifo_empty, 1'b1);

    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'h11);
    check_eq("ovf_sticky", fifo_overflow, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b0, 8'h00);

    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i));
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    check_eq("midrst_seg2", seg2, panel(0));

    input1 = 10'b0000100000;
    input2 = 10'b0000000100;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check_eq("w8_seg1", seg1, panel(0));
    check_eq("w8_seg2", seg2, panel(8));

    input1 = 10'b1000000000;
    input2 = 10'b0000000010;
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check_eq("sat_seg1", seg1, panel(9));
    check_eq("sat_seg2", seg2, panel(9));

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 10);
        oh = (k == 10) ? 10'd0 : (10'd1 << k);
        input1 = oh | (10'($urandom) & (oh - 10'd1));
        k = $urandom_range(0, 10);
        oh = (k == 10) ? 10'd0 : (10'd1 << k);
        input2 = oh | (10'($urandom) & (oh - 10'd1));
      end
      if ($urandom_range(0, 99) == 0) begin
        compare_all();
        do_reset();
      end else begin
        k = $urandom_range(0, 3);
        step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 40 + 10 * k), 8'($urandom));
      end
    end
    compare_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_fifo_mem.md
Name: bank_fifo_mem

Overview:
- 16-entry x 8-bit synchronous FIFO that models a bank customer line, with full/empty/threshold/overflow/underflow flags.
- Also computes an estimated wait time from queue occupancy, per-customer service time (input1) and active teller count (input2).
- Shows that wait time on two 7-segment digits: seg1 = tens, seg2 = units.
- Sits between ticket-issue logic (wr), teller-call logic (rd) and the front-panel display.

Parameters:
- DATA_W, 8, FIFO data width.
- DEPTH, 16, number of FIFO entries (power of two).
- ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits.
- THRESH, 8, occupancy at or above which fifo_threshold asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr  in  1  write request; data_in pushed on the clk edge if accepted.
- rd  in  1  read request; head entry popped on the clk edge if accepted.
- data_in  in  8  customer ticket data.
- input1  in  10  one-hot service time in minutes: bit k set means T=k.
- input2  in  10  one-hot teller count: bit k set means N=k.
- seg1  out  7  tens digit of wait time, segments {g,f,e,d,c,b,a}.
- seg2  out  7  units digit of wait time, same encoding.
- fifo_full  out  1  count == 16.
- fifo_empty  out  1  count == 0.
- fifo_threshold  out  1  count >= THRESH.
- fifo_overflow  out  1  sticky: a write was rejected.
- fifo_underflow  out  1  sticky: a read was rejected.
- data_out  out  8  head entry (last port).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wptr=rptr=0, overflow=underflow=0.
  - Memory contents are not cleared.
  - Outputs after reset: empty=1, full=0, threshold=0, seg1=seg2=digit 0 (7'h3F).
- Reset mid-operation discards all queued entries.
- Pointers are 5 bits; the MSB is the wrap bit.
  - empty = (wptr==rptr).
  - full = (addr bits equal AND MSBs differ).
  - count = wptr - rptr, modulo 32.
- Full, empty and threshold are combinational from the pointers; they update the cycle after the accepting edge.
- Write accept = wr & (~full | rd). On accept: mem[wptr[3:0]] <= data_in; wptr+1.
- Read accept = rd & ~empty. On accept: rptr+1.
- data_out = mem[rptr[3:0]], combinational (first-word fall-through).
  - data_out is valid whenever empty=0; a consumer samples it on the same edge that rd is accepted.
  - When empty, data_out holds the stale entry.
- Simultaneous rd & wr:
  - Full: both accepted, count unchanged, no overflow.
  - Empty: write accepted, read rejected, underflow set.
  - Otherwise both accepted.
- Overflow is set on wr & full & ~rd; underflow is set on rd & empty. Both stay set until reset.
- Wait time:
  - T = index of the highest set bit of input1; 0 if none set.
  - N = index of the highest set bit of input2; 0 or none is treated as 1.
  - W = ceil(count*T / N), saturated to 99.
  - Width: count*T <= 144, 8-bit unsigned; divider is combinational.
- Display:
  - seg1 = 7-seg(W/10), seg2 = 7-seg(W%10). Active-high unless the optional feature is enabled.
  - Digit codes 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Segment outputs are registered, so they lag the count by one cycle.

Optional Feature:
- Macro SEG_ACTIVE_LOW_EN.
- Defined: seg1/seg2 are bitwise inverted for common-anode displays; reset value is 7'h40.
- Undefined: segments are active-high as above.

Decomposition:
- Package bank_fifo_pkg holds:
  - DATA_W, DEPTH, ADDR_W, THRESH.
  - Wait saturation constant 99.
  - The 10-entry 7-segment code table.
- One sub-module, seg7_decoder: 4-bit digit in, 7-bit segments out, honours SEG_ACTIVE_LOW_EN.

Test Plan:
- Reset, then 16 writes of 0x01..0x10:
  - full=1 and threshold=1; threshold first asserts after the 8th write.
  - No overflow.
- 17th write (0x11) while full:
  - overflow=1 and stays set.
  - Count stays 16; 0x11 is not stored.
- 17 single-cycle reads after the fill above:
  - data_out = 0x01..0x10 in order, each matching at its read edge.
  - empty=1 after the 16th read; the 17th read sets underflow=1.
- Simultaneous rd & wr:
  - When full: count stays 16, no overflow.
  - When empty: count becomes 1, underflow=1.
- Wait time:
  - input1=10'b0000100000 (T=5), input2=10'b0000000100 (N=2), count=3: W=8, seg1=3F, seg2=7F.
  - With count=16, N=1, T=9: W saturates to 99, seg1=seg2=6F.
- Reset asserted mid-fill at count=5: empty=1, seg1=seg2=3F, flags cleared next cycle.
